bus2st_unpack: RTL and testbench

- Reverse direction of the decoder output path: takes wide parallel bus words, already in the clk_st domain, and unpacks them into the ST-wide Avalon-ST beat stream that feeds the turbo decoder input.
- Buffers two bus words (ping-pong), so the upstream word source and the ST consumer can stall independently.
- Frames every NUM_BUS_PER_PKT words as one turbo packet, with sop on the first beat and eop on the last.

---
 rtl/bus2st_unpack.sv | 121 ++++++++++++
 tb/tb_bus2st_unpack.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus2st_unpack.sv
// Unpacks BUS_W-bit bus words from a two-entry ping-pong buffer into ST-bit Avalon-ST beats.
// Packets span NUM_BUS_PER_PKT words. Optional macro BUS2ST_PKTCNT_EN adds a 16-bit pkt_cnt output.
module bus2st_unpack #(
    parameter int BUS_W           = 512,
    parameter int ST              = 8,
    parameter int NUM_BUS_PER_PKT = 2
) (
    input  logic             clk_st,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] bus_data,
    input  logic             bus_valid,
    output logic             bus_ready,
    output logic [ST-1:0]    st_data,
    output logic             st_valid,
    output logic             st_sop,
    output logic             st_eop,
    input  logic             st_ready,
    output logic             busy
`ifdef BUS2ST_PKTCNT_EN
    ,
    output logic [15:0]      pkt_cnt
`endif
);

    localparam int NUM_ST_PER_BUS = BUS_W / ST;
    localparam int BW = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
    localparam int WW = (NUM_BUS_PER_PKT > 1) ? $clog2(NUM_BUS_PER_PKT) : 1;

    // Handshakes: a word moves on bus_valid & bus_ready, a beat on st_valid & st_ready;
    // neither ready depends combinationally on its own valid, and valid/data hold while stalled.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STREAM  = 2'd1,
        S_STARVED = 2'd2
    } state_t;

    logic [BUS_W-1:0] buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [BW-1:0]    beat_idx;
    logic [WW-1:0]    word_idx;
    state_t           state;

    logic push;
    logic xfer;
    logic last_beat;
    logic last_word;
    logic pop;

    assign last_beat = (beat_idx == BW'(NUM_ST_PER_BUS - 1));
    assign last_word = (word_idx == WW'(NUM_BUS_PER_PKT - 1));

    // Outputs are gated by rst_n so they read inactive while reset is held.
    assign bus_ready = rst_n & (count != 2'd2);
    assign st_valid  = rst_n & (count != 2'd0);
    assign st_data   = buf_mem[rd_ptr][int'(beat_idx) * ST +: ST];
    assign st_sop    = st_valid & (word_idx == '0) & (beat_idx == '0);
    assign st_eop    = st_valid & last_word & last_beat;

    assign push = bus_valid & bus_ready;
    assign xfer = st_valid & st_ready;
    assign pop  = xfer & last_beat;

    // State is a view of the counters, kept as a named signal for checkers.
    always_comb begin
        state = S_IDLE;
        if (count != 2'd0) begin
            state = S_STREAM;
        end else if ((word_idx != '0) || (beat_idx != '0)) begin
            state = S_STARVED;
        end
    end

    assign busy = rst_n & (state != S_IDLE);

    always_ff @(posedge clk_st) begin
        if (push) begin
            buf_mem[wr_ptr] <= bus_data;
        end
    end

    always_ff @(posedge clk_st) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            beat_idx <= '0;
            word_idx <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (xfer) begin
                if (last_beat) begin
                    beat_idx <= '0;
                    rd_ptr   <= ~rd_ptr;
                    word_idx <= last_word ? '0 : word_idx + WW'(1);
                end else begin
                    beat_idx <= beat_idx + BW'(1);
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef BUS2ST_PKTCNT_EN
    always_ff @(posedge clk_st) begin
        if (!rst_n) begin
            pkt_cnt <= 16'd0;
        end else if (xfer && st_eop) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus2st_unpack.sv
// Scoreboard bench for bus2st_unpack: drivers push words and expected beats, a monitor pops and compares.
module tb_bus2st_unpack;

    localparam int BUS_W = 512;
    localparam int ST    = 8;
    localparam int NBEAT = BUS_W / ST;
    localparam int NWORD = 2;

    // clock / reset
    logic clk_st = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_st = ~clk_st;

    logic [BUS_W-1:0] bus_data  = '0;
    logic             bus_valid = 1'b0;
    logic             bus_ready;
    logic [ST-1:0]    st_data;
    logic             st_valid;
    logic             st_sop;
    logic             st_eop;
    logic             st_ready  = 1'b0;
    logic             busy;
`ifdef BUS2ST_PKTCNT_EN
    logic [15:0]      pkt_cnt;
`endif

    bus2st_unpack #(.BUS_W(BUS_W), .ST(ST), .NUM_BUS_PER_PKT(NWORD)) dut (
        .clk_st   (clk_st),
        .rst_n    (rst_n),
        .bus_data (bus_data),
        .bus_valid(bus_valid),
        .bus_ready(bus_ready),
        .st_data  (st_data),
        .st_valid (st_valid),
        .st_sop   (st_sop),
        .st_eop   (st_eop),
        .st_ready (st_ready),
        .busy     (busy)
`ifdef BUS2ST_PKTCNT_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    // scoreboard state: entry = {sop, eop, data}
    logic [ST+1:0] exp_q[$];
    int n_cmp    = 0;
    int n_fail   = 0;
    int tb_word  = 0;
    int xfer_cnt = 0;
    int sop_cnt  = 0;
    int eop_cnt  = 0;
    int exp_pkt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [BUS_W-1:0] make_word(input int base);
        logic [BUS_W-1:0] w;
        for (int i = 0; i < NBEAT; i++) w[i*ST +: ST] = ST'(base + i);
        return w;
    endfunction

    function automatic logic [BUS_W-1:0] fill_word(input logic [ST-1:0] b);
        logic [BUS_W-1:0] w;
        for (int i = 0; i < NBEAT; i++) w[i*ST +: ST] = b;
        return w;
    endfunction

    task automatic exp_push(input logic [BUS_W-1:0] w);
        for (int i = 0; i < NBEAT; i++) begin
            exp_q.push_back({(tb_word == 0) && (i == 0), (tb_word == NWORD - 1) && (i == NBEAT - 1),
                             w[i*ST +: ST]});
        end
        tb_word = (tb_word + 1) % NWORD;
    endtask

    // driver: call only just after a rising edge
    task automatic push_word(input logic [BUS_W-1:0] w);
        bus_data  = w;
        bus_valid = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_st);
            if (bus_ready) begin
                @(posedge clk_st);
                exp_push(w);
                #1;
                bus_valid = 1'b0;
                return;
            end
        end
        check("push_timeout", 32'd1, 32'd0);
        bus_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(negedge clk_st);
            c++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk_st);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(st_valid), 32'd0);
        @(posedge clk_st);
        #1;
    endtask

    // monitor
    logic          hold_v = 1'b0;
    logic [ST-1:0] hold_d;
    always @(negedge clk_st) begin
        if (!rst_n) begin
            hold_v  = 1'b0;
            exp_pkt = 0;
        end else begin
            logic [ST+1:0] e;
`ifdef BUS2ST_PKTCNT_EN
            check("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt[15:0]));
`endif
            if (hold_v) begin
                check("stall_valid", 32'(st_valid), 32'd1);
                check("stall_data", 32'(st_data), 32'(hold_d));
            end
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 32'(st_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {22'd0, st_sop, st_eop, st_data}, {22'd0, e});
                end
                xfer_cnt++;
                if (st_sop) sop_cnt++;
                if (st_eop) begin
                    eop_cnt++;
                    exp_pkt++;
                end
            end
            hold_v = st_valid && !st_ready;
            hold_d = st_data;
        end
    end

    initial begin
        int base_s, base_e, k, c;
        bit pushes_done;

        // reset
        repeat (3) @(negedge clk_st);
        check("rst_bus_ready", 32'(bus_ready), 32'd0);
        check("rst_st_valid", 32'(st_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk_st);
        #1 rst_n = 1'b1;
        @(negedge clk_st);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ready", 32'(bus_ready), 32'd1);
        @(posedge clk_st);
        #1;

        // one packet at full rate
        st_ready = 1'b1;
        base_s = sop_cnt; base_e = eop_cnt;
        push_word(make_word(8'h00));
        push_word(make_word(8'h40));
        wait_idle();
        check("pkt1_sop", 32'(sop_cnt - base_s), 32'd1);
        check("pkt1_eop", 32'(eop_cnt - base_e), 32'd1);

        // fill buffer with sink stalled
        st_ready = 1'b0;
        push_word(make_word(8'h80));
        @(negedge clk_st);
        check("ready_after_1", 32'(bus_ready), 32'd1);
        @(posedge clk_st); #1;
        push_word(make_word(8'hC0));
        @(negedge clk_st);
        check("ready_after_2", 32'(bus_ready), 32'd0);
        repeat (10) @(negedge clk_st);
        check("ready_held_full", 32'(bus_ready), 32'd0);
        @(posedge clk_st); #1;
        fork
            push_word(make_word(8'h10));
            begin
                repeat (5) @(posedge clk_st);
                #1 st_ready = 1'b1;
            end
        join
        push_word(make_word(8'h50));
        wait_idle();

        // ready pattern 1,0,0,1 over two packets
        base_s = sop_cnt; base_e = eop_cnt;
        pushes_done = 1'b0;
        k = 0;
        fork
            begin
                for (int n = 0; n < 4; n++) push_word(make_word(8'h20 + n * 8'h11));
                pushes_done = 1'b1;
            end
            begin
                while (!(pushes_done && exp_q.size() == 0) && k < 5000) begin
                    st_ready = (k % 4 == 0) || (k % 4 == 3);
                    @(posedge clk_st);
                    #1;
                    k++;
                end
                st_ready = 1'b1;
            end
        join
        wait_idle();
        check("toggle_sop", 32'(sop_cnt - base_s), 32'd2);
        check("toggle_eop", 32'(eop_cnt - base_e), 32'd2);

        // starved gap between the two words of a packet
        push_word(make_word(8'h33));
        repeat (100) @(negedge clk_st);
        check("starved_valid", 32'(st_valid), 32'd0);
        check("starved_busy", 32'(busy), 32'd1);
        @(posedge clk_st); #1;
        push_word(make_word(8'h77));
        wait_idle();

        // reset mid-packet
        base_s = xfer_cnt;
        push_word(make_word(8'h01));
        c = 0;
        while (xfer_cnt - base_s < 40 && c < 1000) begin
            @(posedge clk_st);
            #1;
            c++;
        end
        check("beats40_timeout", 32'(xfer_cnt - base_s >= 40), 32'd1);
        st_ready = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        tb_word = 0;
        @(negedge clk_st);
        check("midrst_valid", 32'(st_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk_st);
        #1 rst_n = 1'b1;
        st_ready = 1'b1;
        push_word(fill_word(8'hA5));
        @(negedge clk_st);
        check("a5_first", {23'd0, st_sop, st_data}, {23'd0, 1'b1, 8'hA5});
        @(posedge clk_st); #1;
        push_word(make_word(8'h5A));
        wait_idle();

        // extra packets for the packet counter path
        for (int n = 0; n < 3; n++) begin
            push_word(make_word(8'h09 * n));
            push_word(make_word(8'h90 + n));
        end
        wait_idle();

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
